// File: rtl/leap_pkg.sv
// Shared types and constants for the sensor-link frame controller.
package leap_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        CSUM    = 2'd2
    } leap_state_e;

    localparam logic [7:0] LEAP_SYNC    = 8'hA5;
    localparam int         LEAP_CNT_W   = 8;
    localparam int         LEAP_TIMER_W = 16;

endpackage

// File: rtl/leap_sat_cnt.sv
// Saturating event counter with a synchronous clear that beats a same-cycle increment.
module leap_sat_cnt
    import leap_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc_i,
    input  logic                  clr_i,
    output logic [LEAP_CNT_W-1:0] cnt_o
);

    logic [LEAP_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + LEAP_CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/leap_frame_ctrl.sv
// Frame controller: sync hunt, payload collection, checksum and inter-byte timeout,
// feeding a one-entry valid/ready output buffer plus saturating error/drop counters.
module leap_frame_ctrl
    import leap_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = LEAP_SYNC,
    parameter int         PAYLOAD_BYTES  = 3,
    parameter int         TIMEOUT_CYCLES = 8680
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 rx_byte,
    input  logic                       rx_valid,
    input  logic                       rx_frame_err,
    output logic [8*PAYLOAD_BYTES-1:0] frame_data,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    input  logic                       clr_stats,
    output logic [LEAP_CNT_W-1:0]      err_cnt,
    output logic [LEAP_CNT_W-1:0]      drop_cnt,
    output logic [1:0]                 state
);

    localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

    leap_state_e               state_q;
    logic [IDX_W-1:0]          idx_q;
    logic [7:0]                acc_q;
    logic [LEAP_TIMER_W-1:0]   timer_q;
    logic [8*PAYLOAD_BYTES-1:0] payload_q;
    logic [8*PAYLOAD_BYTES-1:0] frameData_q;
    logic                      frameValid_q;

    logic       active;
    logic       errFrame;
    logic       timeoutHit;
    logic       csumDone;
    logic [7:0] csumSum;
    logic       csumGood;
    logic       bufFree;
    logic       errInc;
    logic       dropInc;
    logic       loadFrame;

    // A receiver framing error wins over a byte arriving in the same cycle.
    assign active     = (state_q != HUNT);
    assign errFrame   = active && rx_frame_err;
    assign timeoutHit = active && !rx_frame_err && !rx_valid &&
                        (timer_q == LEAP_TIMER_W'(TIMEOUT_CYCLES - 1));
    assign csumDone   = (state_q == CSUM) && rx_valid && !rx_frame_err;
    assign csumSum    = acc_q + rx_byte;
    assign csumGood   = (csumSum == 8'h00);
    assign bufFree    = !frameValid_q || frame_ready;
    assign loadFrame  = csumDone && csumGood && bufFree;
    assign dropInc    = csumDone && csumGood && !bufFree;
    assign errInc     = errFrame || timeoutHit || (csumDone && !csumGood);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            idx_q        <= '0;
            acc_q        <= '0;
            timer_q      <= '0;
            payload_q    <= '0;
            frameData_q  <= '0;
            frameValid_q <= 1'b0;
        end else begin
            if (frameValid_q && frame_ready) begin
                frameValid_q <= 1'b0;
            end
            if (loadFrame) begin
                frameData_q  <= payload_q;
                frameValid_q <= 1'b1;
            end

            unique case (state_q)
                HUNT: begin
                    timer_q <= '0;
                    if (rx_valid && (rx_byte == SYNC_BYTE)) begin
                        state_q <= COLLECT;
                        idx_q   <= '0;
                        acc_q   <= SYNC_BYTE;
                    end
                end
                COLLECT: begin
                    if (errFrame || timeoutHit) begin
                        state_q <= HUNT;
                        timer_q <= '0;
                    end else if (rx_valid) begin
                        for (int k = 0; k < PAYLOAD_BYTES; k++) begin
                            if (idx_q == IDX_W'(k)) begin
                                payload_q[8*k +: 8] <= rx_byte;
                            end
                        end
                        acc_q   <= acc_q + rx_byte;
                        timer_q <= '0;
                        idx_q   <= idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(PAYLOAD_BYTES - 1)) begin
                            state_q <= CSUM;
                        end
                    end else begin
                        timer_q <= timer_q + LEAP_TIMER_W'(1);
                    end
                end
                CSUM: begin
                    if (errFrame || timeoutHit || csumDone) begin
                        state_q <= HUNT;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + LEAP_TIMER_W'(1);
                    end
                end
                default: begin
                    state_q <= HUNT;
                    timer_q <= '0;
                end
            endcase
        end
    end

    leap_sat_cnt u_errCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (errInc),
        .clr_i (clr_stats),
        .cnt_o (err_cnt)
    );

    leap_sat_cnt u_dropCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (dropInc),
        .clr_i (clr_stats),
        .cnt_o (drop_cnt)
    );

    assign frame_data  = frameData_q;
    assign frame_valid = frameValid_q;
    assign state       = state_q;

endmodule

// File: tb/tb_leap_frame_ctrl.sv
// Self-checking bench for leap_frame_ctrl: constant vector table, directed corner
// sequences and a randomized run against a frame-level reference model.
module tb_leap_frame_ctrl;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         PB   = 3;
    localparam int         TOUT = 8680;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        rx_valid = 1'b0;
    logic        rx_frame_err = 1'b0;
    logic [23:0] frame_data;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic        clr_stats = 1'b0;
    logic [7:0]  err_cnt;
    logic [7:0]  drop_cnt;
    logic [1:0]  state;

    int testsRun = 0;
    int testsFailed = 0;

    leap_frame_ctrl #(
        .SYNC_BYTE      (SYNC),
        .PAYLOAD_BYTES  (PB),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .frame_data   (frame_data),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .clr_stats    (clr_stats),
        .err_cnt      (err_cnt),
        .drop_cnt     (drop_cnt),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Reference model works on whole frames: a list of bytes since sync and an idle count.
    bit          mInFrame;
    logic [7:0]  mBytes[$];
    int          mIdle;
    bit          mValid;
    logic [23:0] mData;
    int          mErr;
    int          mDrop;

    typedef struct {
        logic        v;
        logic [7:0]  b;
        logic        fe;
        logic        rdy;
        logic        clr;
        logic [1:0]  eState;
        logic        eValid;
        logic [23:0] eData;
        logic [7:0]  eErr;
        logic [7:0]  eDrop;
    } vec_t;

    vec_t tbl[7];

    task automatic modelReset();
        mInFrame = 0;
        mBytes.delete();
        mIdle  = 0;
        mValid = 0;
        mData  = '0;
        mErr   = 0;
        mDrop  = 0;
    endtask

    function automatic logic [7:0] frameSum();
        logic [7:0] s = SYNC;
        foreach (mBytes[i]) s = s + mBytes[i];
        return s;
    endfunction

    task automatic modelStep(input bit v, input logic [7:0] b, input bit fe, input bit rdy, input bit clr);
        bit errEv = 0;
        bit dropEv = 0;
        bit bufFree = !mValid || rdy;
        if (mValid && rdy) mValid = 0;
        if (mInFrame) begin
            if (fe) begin
                errEv = 1;
                mInFrame = 0;
            end else if (v) begin
                mIdle = 0;
                mBytes.push_back(b);
                if (mBytes.size() == PB + 1) begin
                    mInFrame = 0;
                    if (frameSum() == 8'h00) begin
                        if (bufFree) begin
                            mValid = 1;
                            for (int k = 0; k < PB; k++) mData[8*k +: 8] = mBytes[k];
                        end else begin
                            dropEv = 1;
                        end
                    end else begin
                        errEv = 1;
                    end
                end
            end else begin
                mIdle++;
                if (mIdle == TOUT) begin
                    errEv = 1;
                    mInFrame = 0;
                end
            end
        end else if (v && b == SYNC) begin
            mInFrame = 1;
            mBytes.delete();
            mIdle = 0;
        end
        if (clr) begin
            mErr = 0;
            mDrop = 0;
        end else begin
            if (errEv && mErr < 255) mErr++;
            if (dropEv && mDrop < 255) mDrop++;
        end
    endtask

    function automatic logic [42:0] modelPacked();
        logic [1:0] s;
        if (!mInFrame) s = 2'd0;
        else if (mBytes.size() < PB) s = 2'd1;
        else s = 2'd2;
        return {s, mValid, mData, mErr[7:0], mDrop[7:0]};
    endfunction

    task automatic checkField(input string name, input logic [42:0] act, input logic [42:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string name, input logic [42:0] exp);
        checkField(name, {state, frame_valid, frame_data, err_cnt, drop_cnt}, exp);
    endtask

    // One cycle: drive inputs just after an edge, advance the model, sample 1 time unit after the next edge.
    task automatic applyStimulus(input bit v, input logic [7:0] b, input bit fe, input bit rdy, input bit clr);
        rx_valid = v;
        rx_byte = b;
        rx_frame_err = fe;
        frame_ready = rdy;
        clr_stats = clr;
        modelStep(v, b, fe, rdy, clr);
        @(posedge clk);
        #1;
        checkOutput("model", modelPacked());
    endtask

    task automatic sendByte(input logic [7:0] b, input bit rdy);
        applyStimulus(1, b, 0, rdy, 0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0, rdy, 0);
    endtask

    task automatic sendFrame(input logic [23:0] pay, input bit good, input bit rdy);
        logic [7:0] s = SYNC;
        sendByte(SYNC, rdy);
        for (int k = 0; k < PB; k++) begin
            sendByte(pay[8*k +: 8], rdy);
            s = s + pay[8*k +: 8];
        end
        s = 8'h00 - s;
        if (!good) s = s + 8'h01;
        sendByte(s, rdy);
    endtask

    initial begin
        modelReset();
        tbl[0] = '{1, 8'hA5, 0, 1, 0, 2'd1, 0, 24'h000000, 8'd0, 8'd0};
        tbl[1] = '{1, 8'h01, 0, 1, 0, 2'd1, 0, 24'h000000, 8'd0, 8'd0};
        tbl[2] = '{1, 8'h02, 0, 1, 0, 2'd1, 0, 24'h000000, 8'd0, 8'd0};
        tbl[3] = '{1, 8'h03, 0, 1, 0, 2'd2, 0, 24'h000000, 8'd0, 8'd0};
        tbl[4] = '{1, 8'h55, 0, 1, 0, 2'd0, 1, 24'h030201, 8'd0, 8'd0};
        tbl[5] = '{0, 8'h00, 0, 1, 0, 2'd0, 0, 24'h030201, 8'd0, 8'd0};
        tbl[6] = '{0, 8'h00, 0, 0, 0, 2'd0, 0, 24'h030201, 8'd0, 8'd0};

        #12;
        checkOutput("reset_state", 43'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(tbl[i].v, tbl[i].b, tbl[i].fe, tbl[i].rdy, tbl[i].clr);
            checkOutput($sformatf("table_row%0d", i),
                        {tbl[i].eState, tbl[i].eValid, tbl[i].eData, tbl[i].eErr, tbl[i].eDrop});
        end

        // Bad checksum followed by a good frame.
        sendFrame(24'h030201, 0, 1);
        checkField("badcsum_err", {35'd0, err_cnt}, 43'd1);
        checkField("badcsum_state_valid", {40'd0, state, frame_valid}, 43'd0);
        sendFrame(24'h0C0B0A, 1, 1);
        checkField("after_bad_good", {frame_valid, frame_data}, {1'b1, 24'h0C0B0A});
        applyStimulus(0, 0, 0, 1, 1);

        // Inter-byte timeout; the trailing bytes carry no sync and are ignored.
        sendByte(SYNC, 1);
        sendByte(8'h01, 1);
        idle(TOUT - 1, 1);
        checkField("pre_timeout_state", {41'd0, state}, 43'd1);
        idle(1, 1);
        checkField("timeout", {33'd0, state, err_cnt}, {33'd0, 2'd0, 8'd1});
        sendByte(8'h02, 1);
        sendByte(8'h03, 1);
        sendByte(8'h55, 1);
        checkField("post_timeout", {32'd0, state, frame_valid, err_cnt}, {32'd0, 2'd0, 1'b0, 8'd1});
        applyStimulus(0, 0, 0, 1, 1);

        // Backpressure: second frame dropped, third loads as the buffer drains.
        sendFrame(24'h030201, 1, 0);
        sendFrame(24'h060504, 1, 0);
        checkField("bp_hold", {frame_valid, frame_data, drop_cnt}, {1'b1, 24'h030201, 8'd1});
        sendByte(SYNC, 0);
        sendByte(8'h07, 0);
        sendByte(8'h08, 0);
        sendByte(8'h09, 0);
        sendByte(8'h43, 1);
        checkField("bp_third", {frame_valid, frame_data, drop_cnt}, {1'b1, 24'h090807, 8'd1});
        idle(1, 1);
        checkField("bp_drain", {42'd0, frame_valid}, 43'd0);

        // Sync value inside the payload is data; four A5 bytes need checksum 0x6C.
        sendByte(SYNC, 1);
        sendByte(SYNC, 1);
        sendByte(SYNC, 1);
        sendByte(SYNC, 1);
        sendByte(8'h6C, 1);
        checkField("sync_in_payload", {frame_valid, frame_data}, {1'b1, 24'hA5A5A5});

        // Framing error with a simultaneous byte still aborts the frame.
        applyStimulus(0, 0, 0, 1, 1);
        sendByte(SYNC, 1);
        sendByte(8'h01, 1);
        applyStimulus(1, 8'h02, 1, 1, 0);
        checkField("frame_err", {33'd0, state, err_cnt}, {33'd0, 2'd0, 8'd1});

        // Asynchronous reset mid-frame with a buffered frame and non-zero counters.
        sendFrame(24'h112233, 1, 0);
        sendFrame(24'h445566, 0, 0);
        sendByte(SYNC, 0);
        sendByte(8'h01, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 43'd0);
        modelReset();
        rx_valid = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Error counter saturation, then a clear that coincides with an error.
        for (int f = 0; f < 300; f++) sendFrame(24'h030201, 0, 1);
        checkField("err_saturate", {35'd0, err_cnt}, 43'd255);
        sendByte(SYNC, 1);
        sendByte(8'h01, 1);
        sendByte(8'h02, 1);
        sendByte(8'h03, 1);
        applyStimulus(1, 8'h00, 0, 1, 1);
        checkField("clr_wins", {35'd0, err_cnt}, 43'd0);

        // Randomized traffic against the frame-level model.
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] b;
            bit v = ($urandom_range(0, 2) != 0);
            b = 8'($urandom_range(0, 255));
            if (!mInFrame && $urandom_range(0, 2) == 0) b = SYNC;
            if (mInFrame && mBytes.size() == PB && $urandom_range(0, 1) == 1) b = 8'h00 - frameSum();
            applyStimulus(v, b, ($urandom_range(0, 49) == 0), bit'($urandom_range(0, 1)),
                          ($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
